// File: rtl/ysyx_201979054_mem_req_arbiter.sv
// Arbiter and sequencer for the single AXI master port shared by NUM_CH requesters.
// A winner is chosen in IDLE (round-robin or fixed priority). Its grant is held for the
// whole read burst or write. Read beats are counted, and the granted channel gets exactly
// one done or error pulse per transaction.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | no transaction; arbitrate when any request is present
// S_ISSUE | grant asserted, one-cycle start pulse, counters cleared
// S_READ  | counting read beats until last beat or timeout
// S_WRITE | waiting for the write response or timeout
// S_DONE  | one-cycle done pulse to the granted channel
// S_ERR   | one-cycle error pulse (timeout or beat-count mismatch)
module ysyx_201979054_mem_req_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int BURST_LEN   = 16,
    parameter int PRIO_MODE   = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic [NUM_CH-1:0]                i_req,
    input  logic [NUM_CH-1:0]                i_req_write,
    input  logic                             i_r_valid,
    input  logic                             i_r_last,
    input  logic                             i_b_resp,
    output logic [NUM_CH-1:0]                o_grant,
    output logic                             o_start_read,
    output logic                             o_start_write,
    output logic [NUM_CH-1:0]                o_done,
    output logic [NUM_CH-1:0]                o_error,
    output logic [$clog2(BURST_LEN+1)-1:0]   o_beat_cnt,
    output logic                             o_busy
);

    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(BURST_LEN + 1);
    // The timeout counter only needs to reach TIMEOUT_CYC-1.
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CW-1:0] BURST_MAX = CW'(BURST_LEN);
    localparam logic [CW:0]   BURST_EXT = (CW+1)'(BURST_LEN);
    localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     win_q, win_d;
    logic              wr_q, wr_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [NUM_CH-1:0] grant_q, grant_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [CW-1:0]     beat_inc;
    logic [CW:0]       beat_nxt;
    logic              last_ok;
    logic              tmo_hit;

    // Winner selection: in round-robin, search from the pointer upward first, then wrap to 0.
    // Fixed priority just takes the lowest requesting index in the first pass.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pick_found && i_req[i] && (PRIO_MODE != 0 || IW'(i) >= ptr_q)) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!pick_found && i_req[i]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
    end

    // Next-state logic for the sequencer, beat counter, timeout counter and pointer.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        wr_d     = wr_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        tmo_d    = tmo_q;
        grant_d  = grant_q;
        beat_inc = (beat_q == BURST_MAX) ? beat_q : beat_q + CW'(1);
        // Unsaturated count+1 so a burst that overran BURST_LEN never looks complete.
        beat_nxt = {1'b0, beat_q} + (CW+1)'(1);
        last_ok  = (beat_nxt == BURST_EXT);
        tmo_hit  = (TIMEOUT_CYC > 0) && (tmo_q == TMO_LAST);

        case (state_q)
            S_IDLE: begin
                if (|i_req) begin
                    win_d   = pick_idx;
                    wr_d    = i_req_write[pick_idx];
                    grant_d = {{(NUM_CH-1){1'b0}}, 1'b1} << pick_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                beat_d  = '0;
                tmo_d   = '0;
                state_d = wr_q ? S_WRITE : S_READ;
            end
            S_READ: begin
                if (i_r_valid) begin
                    beat_d = beat_inc;
                end
                if (i_r_valid && i_r_last) begin
                    state_d = last_ok ? S_DONE : S_ERR;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: begin
                if (i_b_resp) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = (win_q == LAST_CH) ? '0 : win_q + IW'(1);
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            wr_q    <= 1'b0;
            ptr_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            grant_q <= grant_d;
        end
    end

    assign o_grant       = grant_q;
    assign o_start_read  = (state_q == S_ISSUE) && !wr_q;
    assign o_start_write = (state_q == S_ISSUE) && wr_q;
    assign o_done        = (state_q == S_DONE) ? grant_q : '0;
    assign o_error       = (state_q == S_ERR) ? grant_q : '0;
    assign o_beat_cnt    = beat_q;
    assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_201979054_mem_req_arbiter.sv
// Bench for the memory request arbiter: a round-robin instance and a fixed-priority
// instance share stimulus; a select picks which one is observed. The driver pushes
// expected grants and completions into queues; a monitor pops and compares them.
module tb_ysyx_201979054_mem_req_arbiter;

    localparam int N   = 4;
    localparam int BL  = 16;
    localparam int TMO = 32;

    logic       clk;
    logic       arst;
    logic [3:0] i_req;
    logic [3:0] i_req_write;
    logic       i_r_valid;
    logic       i_r_last;
    logic       i_b_resp;

    logic [3:0] a_grant, b_grant, a_done, b_done, a_error, b_error;
    logic       a_sr, b_sr, a_sw, b_sw, a_busy, b_busy;
    logic [4:0] a_beat, b_beat;

    logic       sel;
    logic [3:0] m_grant, m_done, m_error;
    logic       m_sr, m_sw, m_busy;
    logic [4:0] m_beat;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    bit  prio     = 1'b0;
    int  rr_ptr   = 0;
    bit  prev_pulse = 1'b0;

    logic [4:0]  gq[$];
    logic [12:0] cq[$];
    logic [4:0]  ge;
    logic [12:0] ce;
    logic [3:0]  cur_grant = '0;

    ysyx_201979054_mem_req_arbiter #(
        .NUM_CH(N), .BURST_LEN(BL), .PRIO_MODE(0), .TIMEOUT_CYC(TMO)
    ) dut_rr (
        .clk(clk), .arst(arst), .i_req(i_req), .i_req_write(i_req_write),
        .i_r_valid(i_r_valid), .i_r_last(i_r_last), .i_b_resp(i_b_resp),
        .o_grant(a_grant), .o_start_read(a_sr), .o_start_write(a_sw),
        .o_done(a_done), .o_error(a_error), .o_beat_cnt(a_beat), .o_busy(a_busy)
    );

    ysyx_201979054_mem_req_arbiter #(
        .NUM_CH(N), .BURST_LEN(BL), .PRIO_MODE(1), .TIMEOUT_CYC(TMO)
    ) dut_fp (
        .clk(clk), .arst(arst), .i_req(i_req), .i_req_write(i_req_write),
        .i_r_valid(i_r_valid), .i_r_last(i_r_last), .i_b_resp(i_b_resp),
        .o_grant(b_grant), .o_start_read(b_sr), .o_start_write(b_sw),
        .o_done(b_done), .o_error(b_error), .o_beat_cnt(b_beat), .o_busy(b_busy)
    );

    assign m_grant = sel ? b_grant : a_grant;
    assign m_done  = sel ? b_done  : a_done;
    assign m_error = sel ? b_error : a_error;
    assign m_sr    = sel ? b_sr    : a_sr;
    assign m_sw    = sel ? b_sw    : a_sw;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_beat  = sel ? b_beat  : a_beat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event expected one at %0t", name, $time);
    endtask

    // Reference arbitration: lowest index in fixed priority, else first at/after pointer.
    function automatic int model_winner(input logic [3:0] req);
        if (prio) begin
            for (int i = 0; i < N; i++) if (req[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (req[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
        end
        return 0;
    endfunction

    // Monitor: invariants every cycle, grant/start on start pulses, completions on pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy_vs_grant", 32'(m_busy), 32'(|m_grant));
            chk("pulse_exclusive", 32'({$onehot0(m_done), $onehot0(m_error), !((|m_done) && (|m_error))}), 32'h7);
            if (m_sr || m_sw) begin
                if (gq.size() == 0) begin
                    fail_now("unexpected_start");
                end else begin
                    ge = gq.pop_front();
                    chk("grant", 32'(m_grant), 32'(ge[3:0]));
                    chk("start_dir", 32'({m_sw, m_sr}), ge[4] ? 32'h2 : 32'h1);
                    cur_grant = ge[3:0];
                end
            end else if (m_busy) begin
                chk("grant_stable", 32'(m_grant), 32'(cur_grant));
            end
            if ((|m_done) || (|m_error)) begin
                if (cq.size() == 0) begin
                    fail_now("unexpected_completion");
                end else begin
                    ce = cq.pop_front();
                    chk("done_vec", 32'(m_done), 32'(ce[12:9]));
                    chk("error_vec", 32'(m_error), 32'(ce[8:5]));
                    chk("beat_cnt", 32'(m_beat), 32'(ce[4:0]));
                end
            end
        end
    end

    task automatic reset_dut();
        arst = 1'b1;
        i_r_valid = 1'b0; i_r_last = 1'b0; i_b_resp = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", 32'({m_grant, m_sr, m_sw, m_done, m_error, m_beat, m_busy}), 32'h0);
        end
        arst = 1'b0;
        rr_ptr = 0;
        prev_pulse = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (m_sr || m_sw) return;
        end
        fail_now("start_wait");
        lat = -1;
    endtask

    // One transaction: read with last beat at beat last_at, or write with response at
    // WRITE cycle bresp_at (-1 = never). hold keeps i_req asserted after the grant.
    task automatic txn(input logic [3:0] req, input logic [3:0] wr, input int last_at,
                       input int bresp_at, input bit hold);
        int w, lat, cyc, beat, gaps, exp_cyc;
        bit is_wr, exp_ok, got;
        logic [3:0] oh;
        logic [4:0] exp_beat;
        w = model_winner(req);
        is_wr = wr[w];
        oh = 4'(1 << w);
        if (is_wr) begin
            exp_ok   = (bresp_at >= 0) && (bresp_at <= TMO - 1);
            exp_beat = 5'd0;
            exp_cyc  = exp_ok ? bresp_at : TMO - 1;
        end else begin
            exp_ok   = (last_at == BL);
            exp_beat = 5'((last_at > BL) ? BL : last_at);
            exp_cyc  = 0;
        end
        gq.push_back({is_wr, oh});
        cq.push_back({exp_ok ? oh : 4'h0, exp_ok ? 4'h0 : oh, exp_beat});
        i_req = req;
        i_req_write = wr;
        wait_start(lat);
        chk("start_latency", 32'(lat), prev_pulse ? 32'd2 : 32'd1);
        if (!hold) i_req = '0;
        i_r_valid = 1'b1;
        i_r_last  = 1'b1;
        @(negedge clk);
        cyc = 0; beat = 0; gaps = 0; got = 1'b0;
        for (int step = 0; step < 80; step++) begin
            if (is_wr) begin
                i_b_resp  = (cyc == bresp_at);
                i_r_valid = 1'($urandom_range(0, 1));
                i_r_last  = 1'($urandom_range(0, 1));
            end else if (beat < last_at && !(gaps < 6 && $urandom_range(0, 3) == 0)) begin
                beat++;
                i_r_valid = 1'b1;
                i_r_last  = (beat == last_at);
            end else begin
                if (beat < last_at) gaps++;
                i_r_valid = 1'b0;
                i_r_last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if ((|m_done) || (|m_error)) begin
                got = 1'b1;
                break;
            end
            cyc++;
        end
        i_r_valid = 1'b0; i_r_last = 1'b0; i_b_resp = 1'b0;
        if (!got) begin
            fail_now("completion_wait");
            cq.delete();
        end else begin
            if (!is_wr) exp_cyc = last_at - 1 + gaps;
            chk("complete_cycle", 32'(cyc), 32'(exp_cyc));
        end
        rr_ptr = (w + 1) % N;
        prev_pulse = 1'b1;
    endtask

    task automatic rand_txn();
        logic [3:0] req, wr;
        int la, ba;
        req = 4'($urandom_range(1, 15));
        wr  = 4'($urandom_range(0, 15));
        la  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 17)) : BL;
        ba  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 24));
        txn(req, wr, la, ba, 1'($urandom_range(0, 1)));
    endtask

    task automatic mid_burst_reset();
        int w, lat;
        w = model_winner(4'b1111);
        gq.push_back({1'b0, 4'(1 << w)});
        i_req = 4'b1111;
        i_req_write = 4'b0000;
        wait_start(lat);
        chk("start_latency", 32'(lat), prev_pulse ? 32'd2 : 32'd1);
        i_req = '0;
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            i_r_valid = 1'b1;
            i_r_last  = 1'b0;
            @(negedge clk);
        end
        chk("beat_cnt_mid", 32'(m_beat), 32'd5);
        reset_dut();
    endtask

    initial begin
        sel = 1'b0;
        arst = 1'b1;
        i_req = 4'b1111;
        i_req_write = 4'b0000;
        i_r_valid = 1'b0; i_r_last = 1'b0; i_b_resp = 1'b0;
        reset_dut();
        mon_en = 1'b1;

        // Round-robin: all requesting, full reads -> ch0,1,2,3,0
        repeat (5) txn(4'b1111, 4'b0000, BL, -1, 1'b1);
        repeat (6) rand_txn();
        i_req = '0;
        mid_burst_reset();
        txn(4'b1111, 4'b0000, BL, -1, 1'b0);
        txn(4'b0100, 4'b0000, BL, -1, 1'b0);
        i_req = '0;

        // Fixed priority instance
        sel = 1'b1;
        prio = 1'b1;
        reset_dut();
        txn(4'b1010, 4'b0000, BL, -1, 1'b1);
        txn(4'b1010, 4'b1111, 0, 5, 1'b1);
        txn(4'b1010, 4'b0000, BL, -1, 1'b1);
        txn(4'b1010, 4'b0000, 8, -1, 1'b0);
        txn(4'b0001, 4'b0000, BL + 1, -1, 1'b0);
        txn(4'b0100, 4'b0000, 1, -1, 1'b0);
        txn(4'b1000, 4'b1000, 0, -1, 1'b0);
        txn(4'b1000, 4'b1000, 0, TMO - 1, 1'b0);
        txn(4'b1000, 4'b1000, 0, TMO, 1'b0);
        repeat (6) rand_txn();
        i_req = '0;
        repeat (4) @(negedge clk);
        chk("queues_drained", 32'(gq.size() + cq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

endmodule
